// File: rtl/mio_bus_pkg.sv
// -----------------------------------------------------------------------------
// mio_bus_pkg
// Shared constants for the MIO bus arbiter slice:
//   - FSM state encodings (IDLE / GNT_IF / GNT_MEM)
//   - requester identifiers used for the round-robin history bit
//   - default timeout and wait-counter width
//   - arbitration helper that decides whether MEM wins an IDLE cycle
// -----------------------------------------------------------------------------
package mio_bus_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GNT_IF  = 2'd1;
    localparam logic [1:0] ST_GNT_MEM = 2'd2;

    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int unsigned CNT_W_DEFAULT   = 10;

    // MEM wins when it is eligible and either IF is not eligible or MEM
    // did not have the previous grant; this alternation keeps fetch alive.
    function automatic logic arb_pick_mem(
        input logic if_ok,
        input logic mem_ok,
        input logic last_grant
    );
        return mem_ok & (~if_ok | (last_grant != REQ_MEM));
    endfunction

endpackage

// File: rtl/mio_wait_timer.sv
// -----------------------------------------------------------------------------
// mio_wait_timer
// Wait-state counter for one bus grant.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   i_clr      : synchronous clear (held while the arbiter is idle)
//   i_en       : count one waiting cycle
//   o_expired  : count has reached TIMEOUT
// -----------------------------------------------------------------------------
module mio_wait_timer
    import mio_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Wait counter: cleared on request, stops once the limit is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != LP_LIMIT)) begin
            r_count <= r_count + LP_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (r_count == LP_LIMIT);

endmodule

// File: rtl/mio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mio_bus_arbiter
// Shares the single CPU memory/IO bus between instruction fetch (IF) and data
// access (MEM), runs the MIO_ready handshake, returns read data with a
// one-cycle ack pulse and bounds each transaction with a timeout.
//
// Ports:
//   clk, reset                     : clock, asynchronous active-low reset
//   if_req/if_addr                 : fetch request and address
//   if_rdata/if_ack                : fetch data, one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata : data request, store flag, addr, data
//   mem_rdata/mem_ack              : load data, one-cycle completion pulse
//   bus_addr/bus_wdata/bus_we/bus_req : to Addr_out/Data_out/mem_w/CPU_MIO
//   bus_rdata/MIO_ready            : from Data_in and the bus ready line
//   stall_if/stall_mem             : req & ~ack, combinational
//   timeout_err                    : sticky timeout flag, cleared by reset
//
// Timeout: the counter starts at 0 in the first grant cycle and advances on
// every cycle without MIO_ready. The grant cycle in which the counter equals
// TIMEOUT is the last one sampled; if MIO_ready is still low there, the
// transaction is aborted with zero data and an ack.
// -----------------------------------------------------------------------------
module mio_bus_arbiter
    import mio_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_req,
    input  logic [31:0] bus_rdata,
    input  logic        MIO_ready,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        timeout_err
);

    logic [1:0]  r_state;
    logic        r_last_grant;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic        r_bus_we;
    logic        r_bus_req;
    logic [31:0] r_if_rdata;
    logic [31:0] r_mem_rdata;
    logic        r_if_ack;
    logic        r_mem_ack;
    logic        r_timeout_err;

    logic w_if_ok;
    logic w_mem_ok;
    logic w_pick_mem;
    logic w_granted;
    logic w_expired;
    logic w_done;
    logic [31:0] w_done_data;

    // A requester being acked this cycle still shows its old req; skip it.
    assign w_if_ok     = if_req  & ~r_if_ack;
    assign w_mem_ok    = mem_req & ~r_mem_ack;
    assign w_pick_mem  = arb_pick_mem(w_if_ok, w_mem_ok, r_last_grant);
    assign w_granted   = (r_state == ST_GNT_IF) | (r_state == ST_GNT_MEM);
    assign w_done      = MIO_ready | w_expired;
    assign w_done_data = MIO_ready ? bus_rdata : 32'h0000_0000;

    mio_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (reset),
        .i_clr     (~w_granted),
        .i_en      (w_granted & ~MIO_ready),
        .o_expired (w_expired)
    );

    // Arbitration FSM, bus drive registers, ack pulses and read-data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= REQ_IF;
            r_bus_addr    <= 32'h0000_0000;
            r_bus_wdata   <= 32'h0000_0000;
            r_bus_we      <= 1'b0;
            r_bus_req     <= 1'b0;
            r_if_rdata    <= 32'h0000_0000;
            r_mem_rdata   <= 32'h0000_0000;
            r_if_ack      <= 1'b0;
            r_mem_ack     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_mem) begin
                        r_state      <= ST_GNT_MEM;
                        r_bus_req    <= 1'b1;
                        r_bus_addr   <= mem_addr;
                        r_bus_we     <= mem_we;
                        r_bus_wdata  <= mem_wdata;
                        r_last_grant <= REQ_MEM;
                    end else if (w_if_ok) begin
                        r_state      <= ST_GNT_IF;
                        r_bus_req    <= 1'b1;
                        r_bus_addr   <= if_addr;
                        r_bus_we     <= 1'b0;
                        r_last_grant <= REQ_IF;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                    end
                end
                ST_GNT_IF, ST_GNT_MEM: begin
                    if (w_done) begin
                        r_state   <= ST_IDLE;
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        if (r_state == ST_GNT_MEM) begin
                            r_mem_ack   <= 1'b1;
                            r_mem_rdata <= w_done_data;
                        end else begin
                            r_if_ack    <= 1'b1;
                            r_if_rdata  <= w_done_data;
                        end
                        if (!MIO_ready) begin
                            r_timeout_err <= 1'b1;
                        end else begin
                            r_timeout_err <= r_timeout_err;
                        end
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_bus_req <= 1'b0;
                    r_bus_we  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign bus_we      = r_bus_we;
    assign bus_req     = r_bus_req;
    assign if_rdata    = r_if_rdata;
    assign mem_rdata   = r_mem_rdata;
    assign if_ack      = r_if_ack;
    assign mem_ack     = r_mem_ack;
    assign timeout_err = r_timeout_err;

    assign stall_if  = if_req  & ~r_if_ack;
    assign stall_mem = mem_req & ~r_mem_ack;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mio_bus_arbiter
// Directed scenarios followed by randomized requester/bus traffic, all
// checked against a transaction-level reference model of the arbiter.
// -----------------------------------------------------------------------------
module tb_mio_bus_arbiter;

    localparam int unsigned TB_TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_req;
    logic [31:0] bus_rdata = 32'h0;
    logic        MIO_ready = 1'b0;
    logic        stall_if;
    logic        stall_mem;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    mio_bus_arbiter #(.TIMEOUT(TB_TO), .CNT_W(10)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
        .bus_req(bus_req), .bus_rdata(bus_rdata), .MIO_ready(MIO_ready),
        .stall_if(stall_if), .stall_mem(stall_mem), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the bus, how long it has waited, and the
    // values the outputs must show in the current cycle.
    int          m_owner;      // 0 = nobody, 1 = fetch, 2 = data
    int          m_waited;
    bit          m_mem_was_last;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_mem_rdata;
    logic        m_we, m_req, m_if_ack, m_mem_ack, m_terr;

    task automatic model_reset();
        m_owner = 0; m_waited = 0; m_mem_was_last = 1'b0;
        m_addr = 32'h0; m_wdata = 32'h0; m_if_rdata = 32'h0; m_mem_rdata = 32'h0;
        m_we = 1'b0; m_req = 1'b0; m_if_ack = 1'b0; m_mem_ack = 1'b0; m_terr = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs seen now.
    task automatic model_next();
        bit fetch_wants, data_wants, finished;
        logic [31:0] got;
        fetch_wants = if_req && !m_if_ack;
        data_wants  = mem_req && !m_mem_ack;
        m_if_ack = 1'b0;
        m_mem_ack = 1'b0;
        if (m_owner == 0) begin
            if (data_wants && !(fetch_wants && m_mem_was_last)) begin
                m_owner = 2; m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata;
                m_mem_was_last = 1'b1; m_req = 1'b1; m_waited = 0;
            end else if (fetch_wants) begin
                m_owner = 1; m_addr = if_addr; m_we = 1'b0;
                m_mem_was_last = 1'b0; m_req = 1'b1; m_waited = 0;
            end
        end else begin
            finished = 1'b0;
            got = 32'h0;
            if (MIO_ready) begin
                finished = 1'b1; got = bus_rdata;
            end else if (m_waited == TB_TO) begin
                finished = 1'b1; m_terr = 1'b1;
            end else begin
                m_waited++;
            end
            if (finished) begin
                if (m_owner == 1) begin m_if_ack = 1'b1; m_if_rdata = got; end
                else begin m_mem_ack = 1'b1; m_mem_rdata = got; end
                m_owner = 0; m_req = 1'b0; m_we = 1'b0;
            end
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk32("bus_addr", bus_addr, m_addr);
        chk32("bus_wdata", bus_wdata, m_wdata);
        chk1("bus_we", bus_we, m_we);
        chk1("bus_req", bus_req, m_req);
        chk32("if_rdata", if_rdata, m_if_rdata);
        chk32("mem_rdata", mem_rdata, m_mem_rdata);
        chk1("if_ack", if_ack, m_if_ack);
        chk1("mem_ack", mem_ack, m_mem_ack);
        chk1("timeout_err", timeout_err, m_terr);
    endtask

    // One clock: check stalls on the settled inputs, cross the edge, check outputs.
    task automatic step();
        #1;
        chk1("stall_if", stall_if, if_req & ~m_if_ack);
        chk1("stall_mem", stall_mem, mem_req & ~m_mem_ack);
        model_next();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] grants [4];
        logic [31:0] order_exp [4];
        int ng;
        int gcycles;

        // Reset state
        model_reset();
        #3;
        check_all();
        #9 reset = 1'b1;
        @(posedge clk); #1;
        check_all();

        // Single fetch, zero wait states
        if_req = 1'b1; if_addr = 32'h0000_0040; MIO_ready = 1'b1; bus_rdata = 32'h2008_0005;
        step();
        chk1("fetch_c1_bus_req", bus_req, 1'b1);
        chk32("fetch_c1_bus_addr", bus_addr, 32'h0000_0040);
        step();
        chk1("fetch_c2_if_ack", if_ack, 1'b1);
        chk32("fetch_c2_if_rdata", if_rdata, 32'h2008_0005);
        if_req = 1'b0;
        step();
        chk1("fetch_c3_if_ack", if_ack, 1'b0);

        // Both requesters held: MEM, IF, MEM, IF
        order_exp[0] = 32'h0000_1000; order_exp[1] = 32'h0000_0080;
        order_exp[2] = 32'h0000_1000; order_exp[3] = 32'h0000_0080;
        if_req = 1'b1; if_addr = 32'h0000_0080;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_1000; mem_wdata = 32'h1234_5678;
        bus_rdata = 32'hCAFE_0001;
        ng = 0;
        for (int k = 0; k < 30 && ng < 4; k++) begin
            step();
            if (bus_req) begin grants[ng] = bus_addr; ng++; end
        end
        chk32("alt_grant_count", 32'(ng), 32'd4);
        for (int k = 0; k < 4; k++) chk32("alt_grant_order", grants[k], order_exp[k]);
        step();
        if_req = 1'b0; mem_req = 1'b0;
        step();

        // Store with three wait states
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'hE000_0000; mem_wdata = 32'hDEAD_BEEF;
        MIO_ready = 1'b0;
        step();
        for (int g = 1; g <= 4; g++) begin
            chk1("store_bus_we", bus_we, 1'b1);
            chk32("store_bus_addr", bus_addr, 32'hE000_0000);
            chk32("store_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
            chk1("store_stall_mem", stall_mem, 1'b1);
            if (g == 4) MIO_ready = 1'b1;
            step();
        end
        chk1("store_mem_ack", mem_ack, 1'b1);
        chk1("store_bus_req_off", bus_req, 1'b0);
        mem_req = 1'b0; mem_we = 1'b0;
        step();
        chk1("store_mem_ack_off", mem_ack, 1'b0);

        // Fetch timeout
        if_req = 1'b1; if_addr = 32'h0000_0100; MIO_ready = 1'b0;
        step();
        gcycles = 0;
        for (int k = 0; k < 20 && !if_ack; k++) begin
            if (bus_req) gcycles++;
            step();
        end
        chk1("to_if_ack", if_ack, 1'b1);
        chk32("to_if_rdata", if_rdata, 32'h0000_0000);
        chk1("to_err", timeout_err, 1'b1);
        chk32("to_grant_cycles", 32'(gcycles), 32'(TB_TO + 1));
        if_req = 1'b0;
        step();
        if_req = 1'b1; if_addr = 32'h0000_0104; MIO_ready = 1'b1; bus_rdata = 32'h0BAD_F00D;
        step();
        step();
        chk32("to_after_rdata", if_rdata, 32'h0BAD_F00D);
        chk1("to_err_sticky", timeout_err, 1'b1);
        if_req = 1'b0;
        step();

        // Reset in the middle of a store grant
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'hE000_0010; mem_wdata = 32'h5555_AAAA;
        MIO_ready = 1'b0;
        step();
        chk1("rst_pre_bus_we", bus_we, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk1("rst_async_bus_req", bus_req, 1'b0);
        chk1("rst_async_bus_we", bus_we, 1'b0);
        chk1("rst_async_if_ack", if_ack, 1'b0);
        chk1("rst_async_mem_ack", mem_ack, 1'b0);
        chk1("rst_async_err", timeout_err, 1'b0);
        model_reset();
        mem_req = 1'b0; mem_we = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0200; MIO_ready = 1'b1; bus_rdata = 32'h7777_0001;
        @(posedge clk); #1;
        check_all();
        #2 reset = 1'b1;
        step();
        chk1("rst_after_bus_req", bus_req, 1'b1);
        chk32("rst_after_bus_addr", bus_addr, 32'h0000_0200);
        step();
        chk1("rst_after_if_ack", if_ack, 1'b1);
        if_req = 1'b0;
        step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (if_req) begin
                if (m_if_ack) begin
                    if_req = ($urandom_range(0, 1) == 0);
                    if_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                end
            end else if ($urandom_range(0, 99) < 40) begin
                if_req = 1'b1;
                if_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            end
            if (mem_req) begin
                if (m_mem_ack) begin
                    mem_req = ($urandom_range(0, 1) == 0);
                    mem_we = $urandom_range(0, 1) == 1;
                    mem_addr = $urandom();
                    mem_wdata = $urandom();
                end
            end else if ($urandom_range(0, 99) < 40) begin
                mem_req = 1'b1;
                mem_we = $urandom_range(0, 1) == 1;
                mem_addr = $urandom();
                mem_wdata = $urandom();
            end
            MIO_ready = ($urandom_range(0, 99) < ((i % 128) < 32 ? 8 : 65));
            bus_rdata = $urandom();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
- Shares the single CPU memory/IO bus (Addr_out, Data_out, mem_w, CPU_MIO, Data_in, MIO_ready) between two pipeline requesters:
  - instruction fetch (IF port)
  - data memory access (MEM port)
- Owns the bus handshake and wait-state handling.
- Returns read data with a one-cycle ack pulse.
- Drives stall signals to the pipeline control.
- Bounds every bus transaction with a timeout so the pipeline cannot hang.

Parameters:
- TIMEOUT, 255, maximum cycles a granted transaction waits for MIO_ready before it is aborted (range 1..1023).
- CNT_W, 10, width of the wait counter (must satisfy 2^CNT_W > TIMEOUT).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held until if_ack.
- if_addr  input  32  fetch address; stable while if_req is high.
- if_rdata  output  32  fetched word; valid only while if_ack is high.
- if_ack  output  1  one-cycle completion pulse for fetch.
- mem_req  input  1  data request; held until mem_ack.
- mem_we  input  1  1 = store, 0 = load.
- mem_addr  input  32  data address.
- mem_wdata  input  32  store data.
- mem_rdata  output  32  load data; valid only while mem_ack is high.
- mem_ack  output  1  one-cycle completion pulse for data.
- bus_addr  output  32  to Addr_out.
- bus_wdata  output  32  to Data_out.
- bus_we  output  1  to mem_w.
- bus_req  output  1  to CPU_MIO; high while a transaction owns the bus.
- bus_rdata  input  32  from Data_in.
- MIO_ready  input  1  bus completion; sampled every cycle of a grant.
- stall_if  output  1  combinational: if_req & ~if_ack.
- stall_mem  output  1  combinational: mem_req & ~mem_ack.
- timeout_err  output  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All registered outputs 0: bus_addr, bus_wdata, bus_we, bus_req, if_rdata, mem_rdata, if_ack, mem_ack, timeout_err.
  - Wait counter 0; last_grant=IF.
  - A transaction in flight is dropped with no ack.
- States: IDLE, GNT_IF, GNT_MEM.
- IDLE arbitration (evaluated every IDLE cycle):
  - Only mem_req pending -> GNT_MEM.
  - Only if_req pending -> GNT_IF.
  - Both pending -> MEM wins unless last_grant=MEM, in which case IF wins. This alternation prevents fetch starvation.
  - The requester whose ack is high in the current cycle is ineligible that cycle, so a stale req is never re-granted.
- Grant entry (registered, effective the cycle after the decision):
  - bus_req=1.
  - bus_addr = the winner's address.
  - GNT_MEM only: bus_we=mem_we, bus_wdata=mem_wdata.
  - GNT_IF: bus_we=0 always.
  - last_grant updated; counter cleared.
- Grant hold:
  - Bus outputs stay stable while MIO_ready=0.
  - The counter increments each waiting cycle.
- Completion, MIO_ready=1 in a grant cycle:
  - Next edge: state=IDLE, bus_req=0, bus_we=0.
  - The winner's rdata register captures bus_rdata (captured for stores too, ignored by the requester).
  - The winner's ack=1 for exactly one cycle.
- Timeout: counter reaches TIMEOUT with MIO_ready still 0:
  - Next edge: state=IDLE, bus_req=0, bus_we=0.
  - Winner's rdata=32'h0 and winner's ack pulses.
  - timeout_err=1.
- Latency with zero wait states: req seen in IDLE at cycle 0 -> grant/bus_req in cycle 1 -> ack in cycle 2.
  - Back-to-back throughput: one transaction per 3 cycles per requester.
- Outside a grant: bus_addr and bus_wdata hold their last values; bus_req=0 and bus_we=0.
- req dropped mid-grant: protocol violation. The transaction still completes and acks; no abort path.
- MIO_ready high while IDLE: ignored.

Decomposition:
- Shared package mio_bus_pkg:
  - state encodings (IDLE=2'd0, GNT_IF=2'd1, GNT_MEM=2'd2)
  - requester IDs (REQ_IF=1'b0, REQ_MEM=1'b1)
  - default TIMEOUT constant
- One sub-module: mio_wait_timer, holding the CNT_W counter with clear/enable and an expired flag at TIMEOUT.
- FSM, muxing and ack/rdata registers live in the top.

Test Plan:
- Single fetch, MIO_ready tied 1: if_req=1, if_addr=32'h0000_0040, bus_rdata=32'h2008_0005.
  - bus_req=1 and bus_addr=32'h40 in cycle 1.
  - if_ack=1 and if_rdata=32'h2008_0005 in cycle 2.
  - if_ack=0 in cycle 3.
- Store with 3 wait states: mem_req=1, mem_we=1, mem_addr=32'hE000_0000, mem_wdata=32'hDEAD_BEEF, MIO_ready rises 3 cycles after grant.
  - bus_we=1 and addr/data stable for 4 grant cycles.
  - mem_ack 1 cycle after ready.
  - stall_mem=1 throughout.
- Simultaneous requests held continuously (both reqs re-asserted after each ack):
  - Grant order is MEM, IF, MEM, IF.
  - bus_addr alternates between mem_addr and if_addr.
  - No grant repeats to a requester in its own ack cycle.
- Timeout with TIMEOUT=4 and MIO_ready held 0 after a fetch grant:
  - Abort after 4 wait cycles.
  - if_ack=1 with if_rdata=0.
  - timeout_err=1 and remains 1 through later successful transactions.
- Reset mid-grant: assert reset=0 during GNT_MEM with bus_we=1.
  - bus_req, bus_we and all acks are 0 immediately (asynchronously), no ack is issued.
  - After release, state is IDLE and a pending if_req is granted normally.
